// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM states, next-PC select codes, word/J-format sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int WORD_BYTES = 4;
  localparam int J_INDEX_W  = 26;
  localparam int J_PC_HI_W  = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } pc_sel_e;

  // A redirect squashes the word fetched in the same cycle.
  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JUMP);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jump > branch > stall > PC+4) with alignment and range checks.
// Latency: purely combinational.
// Backpressure: stall selects the current PC; redirects override it.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 30
) (
  input  logic [31:0]          pc_i,
  input  logic [31:0]          if_id_pc4_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [31:0]          branch_target_i,
  input  logic                 jump_i,
  input  logic [J_INDEX_W-1:0] jump_index_i,
  output logic [31:0]          next_pc_o,
  output logic [31:0]          pc_plus4_o,
  output pc_sel_e              sel_o,
  output logic                 pc_legal_o,
  output logic                 halt_o,
  output logic                 fault_o
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * WORD_BYTES);

  logic [31:0] jump_pc;

  // Wraps modulo 2^32; a wrapped value is still judged by the range check.
  assign pc_plus4_o = pc_i + 32'(WORD_BYTES);
  assign jump_pc    = {if_id_pc4_i[31:32-J_PC_HI_W], jump_index_i, 2'b00};

  // Priority select of the candidate PC.
  always_comb begin
    sel_o     = SEL_SEQ;
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      sel_o     = SEL_JUMP;
      next_pc_o = jump_pc;
    end else if (branch_taken_i) begin
      sel_o     = SEL_BRANCH;
      next_pc_o = branch_target_i;
    end else if (stall_i) begin
      sel_o     = SEL_HOLD;
      next_pc_o = pc_i;
    end
  end

  // Misalignment is a fault; running past the end of memory is a clean stop.
  assign fault_o    = (next_pc_o[1:0] != 2'b00);
  assign halt_o     = fault_o || (next_pc_o >= PC_LIMIT);
  assign pc_legal_o = (pc_i[1:0] == 2'b00) && (pc_i < PC_LIMIT);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: PC register, IF/ID register and BOOT/FETCH/HALT sequencing.
// Latency: word at PC=A appears on if_id_instr one clock later; redirects cost one bubble.
// Backpressure: stall holds PC and IF/ID unless a redirect arrives in the same cycle.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int          IMEM_WORDS = 30,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [J_INDEX_W-1:0] jump_index,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic                 halted,
  output logic                 fault
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc4_q;
  logic         valid_q;
  logic         halted_q;
  logic         fault_q;

  logic [31:0]  pc_d;
  logic [31:0]  pc_plus4;
  pc_sel_e      sel;
  logic         pc_legal;
  logic         halt_req;
  logic         fault_req;

  next_pc_sel #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_next_pc_sel (
    .pc_i           (pc_q),
    .if_id_pc4_i    (pc4_q),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .next_pc_o      (pc_d),
    .pc_plus4_o     (pc_plus4),
    .sel_o          (sel),
    .pc_legal_o     (pc_legal),
    .halt_o         (halt_req),
    .fault_o        (fault_req)
  );

  // FSM with PC and IF/ID update; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
        end
        FETCH: begin
          // IF/ID: squash on redirect, hold on stall, else capture this cycle's word.
          if (is_redirect(sel)) begin
            instr_q <= '0;
            valid_q <= 1'b0;
          end else if (sel == SEL_SEQ) begin
            instr_q <= imem_instr;
            pc4_q   <= pc_plus4;
            valid_q <= pc_legal;
          end
          // PC freezes on the same edge that halted rises.
          if (halt_req) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= fault_q | fault_req;
          end else begin
            pc_q <= pc_d;
          end
        end
        HALT: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  localparam int          IMEM_WORDS = 30;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES  = 32'(IMEM_WORDS * 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;

  logic [31:0] mem [IMEM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the spec says the visible outputs should be.
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_halted, m_fault, m_boot;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .IMEM_WORDS(IMEM_WORDS),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fault        (fault)
  );

  // Asynchronous-read instruction memory.
  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_addr < MEM_BYTES) imem_instr = mem[imem_addr[6:2]];
  end

  // One clock: drive inputs at negedge, advance the reference, sample 1ns after posedge.
  task automatic tick(input bit r, input bit s, input bit b, input logic [31:0] bt,
                      input bit j, input logic [25:0] ji);
    logic [31:0] tgt;
    @(negedge clk);
    rst_n = !r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    if (r) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0;
      m_valid = 0; m_halted = 0; m_fault = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else begin
      if (j)      tgt = {m_pc4[31:28], ji, 2'b00};
      else if (b) tgt = bt;
      else if (s) tgt = m_pc;
      else        tgt = m_pc + 32'd4;
      if (j || b) begin
        m_instr = 0; m_valid = 0;
      end else if (!s) begin
        m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 32'd4; m_valid = 1;
      end
      if (tgt % 4 != 0) begin
        m_halted = 1; m_fault = 1;
      end else if (tgt >= MEM_BYTES) begin
        m_halted = 1;
      end else begin
        m_pc = tgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 0, 32'h0, 0, 26'h0);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 32'h0, 0, 26'h0);
    tick(1, 1, 1, 32'h44, 1, 26'h3);
    n_checks += 6;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_id_instr); end
    if (if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", if_id_pc4); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
  endtask

  task automatic test_seq_fetch();
    idle();
    n_checks += 2;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL boot_addr: got %h want 0", imem_addr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", if_id_valid); end
    idle();
    n_checks += 4;
    if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr1: got %h want 4", imem_addr); end
    if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", if_id_valid); end
    if (if_id_instr !== mem[0]) begin n_fail++; $display("FAIL first_instr: got %h want %h", if_id_instr, mem[0]); end
    if (if_id_pc4 !== 32'h4) begin n_fail++; $display("FAIL first_pc4: got %h want 4", if_id_pc4); end
    idle();
    n_checks += 2;
    if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr2: got %h want 8", imem_addr); end
    if (if_id_instr !== mem[1]) begin n_fail++; $display("FAIL seq_instr2: got %h want %h", if_id_instr, mem[1]); end
  endtask

  task automatic test_stall();
    idle(); idle();  // PC 0x8 -> 0xC -> 0x10
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 32'h0, 0, 26'h0);
      n_checks += 4;
      if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 10", i, imem_addr); end
      if (if_id_instr !== mem[3]) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, if_id_instr, mem[3]); end
      if (if_id_pc4 !== 32'h10) begin n_fail++; $display("FAIL stall_pc4[%0d]: got %h want 10", i, if_id_pc4); end
      if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_id_valid); end
    end
    idle();
    n_checks += 3;
    if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL resume_addr: got %h want 14", imem_addr); end
    if (if_id_instr !== mem[4]) begin n_fail++; $display("FAIL resume_instr: got %h want %h", if_id_instr, mem[4]); end
    if (if_id_pc4 !== 32'h14) begin n_fail++; $display("FAIL resume_pc4: got %h want 14", if_id_pc4); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) idle();  // PC 0x14 -> 0x24
    tick(0, 0, 1, 32'h48, 0, 26'h0);
    n_checks += 3;
    if (imem_addr !== 32'h48) begin n_fail++; $display("FAIL br_addr: got %h want 48", imem_addr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble: got %b want 0", if_id_valid); end
    if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_bubble_instr: got %h want 0", if_id_instr); end
    idle();
    n_checks += 3;
    if (if_id_instr !== mem[18]) begin n_fail++; $display("FAIL br_target_instr: got %h want %h", if_id_instr, mem[18]); end
    if (if_id_pc4 !== 32'h4C) begin n_fail++; $display("FAIL br_target_pc4: got %h want 4c", if_id_pc4); end
    if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br_target_valid: got %b want 1", if_id_valid); end
  endtask

  task automatic test_jump_priority();
    tick(0, 1, 1, 32'h60, 1, 26'h0E);
    n_checks += 2;
    if (imem_addr !== 32'h38) begin n_fail++; $display("FAIL jmp_addr: got %h want 38", imem_addr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_bubble: got %b want 0", if_id_valid); end
    idle();
    n_checks += 2;
    if (if_id_instr !== mem[14]) begin n_fail++; $display("FAIL jmp_target_instr: got %h want %h", if_id_instr, mem[14]); end
    if (if_id_pc4 !== 32'h3C) begin n_fail++; $display("FAIL jmp_target_pc4: got %h want 3c", if_id_pc4); end
  endtask

  task automatic test_end_of_mem();
    tick(0, 0, 1, 32'h70, 0, 26'h0);
    idle();
    n_checks += 2;
    if (imem_addr !== 32'h74) begin n_fail++; $display("FAIL eom_addr: got %h want 74", imem_addr); end
    if (if_id_instr !== mem[28]) begin n_fail++; $display("FAIL eom_w28: got %h want %h", if_id_instr, mem[28]); end
    idle();
    n_checks += 5;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL eom_halted: got %b want 1", halted); end
    if (fault !== 1'b0) begin n_fail++; $display("FAIL eom_fault: got %b want 0", fault); end
    if (imem_addr !== 32'h74) begin n_fail++; $display("FAIL eom_frozen: got %h want 74", imem_addr); end
    if (if_id_instr !== mem[29] || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL eom_w29: got %h/%b want %h/1", if_id_instr, if_id_valid, mem[29]); end
    if (if_id_pc4 !== 32'h78) begin n_fail++; $display("FAIL eom_pc4: got %h want 78", if_id_pc4); end
    idle();
    n_checks += 2;
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b want 0", if_id_valid); end
    if (imem_addr !== 32'h74) begin n_fail++; $display("FAIL halt_addr: got %h want 74", imem_addr); end
    tick(0, 0, 1, 32'h8, 0, 26'h0);
    n_checks += 2;
    if (imem_addr !== 32'h74) begin n_fail++; $display("FAIL halt_ignores_br: got %h want 74", imem_addr); end
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", halted); end
  endtask

  task automatic test_misaligned_reset();
    tick(1, 0, 0, 32'h0, 0, 26'h0);
    idle();
    tick(0, 0, 1, 32'h42, 0, 26'h0);
    n_checks += 4;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL mis_halted: got %b want 1", halted); end
    if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", fault); end
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mis_addr: got %h want 0", imem_addr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", if_id_valid); end
    tick(1, 0, 0, 32'h0, 0, 26'h0);
    n_checks += 3;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    idle(); idle();
    n_checks += 2;
    if (if_id_instr !== mem[0] || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resume: got %h/%b want %h/1", if_id_instr, if_id_valid, mem[0]); end
    if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL rst_resume_addr: got %h want 4", imem_addr); end
  endtask

  task automatic test_random();
    bit r, s, b, j;
    logic [31:0] bt;
    logic [25:0] ji;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r  = ($urandom_range(0, 99) < 1) || (m_halted && $urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 9) == 0);
      j  = ($urandom_range(0, 19) == 0);
      bt = 32'($urandom_range(0, 31)) * 32'd4;
      if ($urandom_range(0, 19) == 0) bt = bt | 32'($urandom_range(1, 3));
      ji = 26'($urandom_range(0, 31));
      tick(r, s, b, bt, j, ji);
      n_checks += 6;
      if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr, m_pc); end
      if (if_id_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, if_id_instr, m_instr); end
      if (if_id_pc4 !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4@%0d: got %h want %h", cyc, if_id_pc4, m_pc4); end
      if (if_id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, if_id_valid, m_valid); end
      if (halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted@%0d: got %b want %b", cyc, halted, m_halted); end
      if (fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault@%0d: got %b want %b", cyc, fault, m_fault); end
    end
  endtask

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0;
    m_valid = 0; m_halted = 0; m_fault = 0; m_boot = 1;
    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch();
    test_jump_priority();
    test_end_of_mem();
    test_misaligned_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
